// File: rtl/ad9826_cfg_sequencer.sv
// ad9826_cfg_sequencer
// Sequences all register traffic into the AD9826 serial configuration engine.
// After reset (or an init_start pulse) the eight AD9826 registers are written
// from init_image; afterwards host read/write requests are passed one at a time
// onto the single engine port.
//
// Optional feature: define AD9826_VERIFY_EN to read back every init write,
// compare it with init_image and rewrite up to RETRIES extra times.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   init_start        pulse: rerun the init sequence (sampled in IDLE only)
//   init_image[71:0]  register k = init_image[9k+8:9k]
//   host_req/word     host request, held with word until host_ack
//   host_ack/rdata    one-cycle completion pulse, readback bits 8:0
//   eng_word/toggle   word and start request to the serial engine
//   eng_idle/rdata    engine idle (async, synchronised here), readback
//   init_done, busy, err  status (err is sticky until reset/init_start)
module ad9826_cfg_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RETRIES        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_start,
  input  logic [71:0] init_image,
  input  logic        host_req,
  input  logic [15:0] host_word,
  output logic        host_ack,
  output logic [8:0]  host_rdata,
  output logic [15:0] eng_word,
  output logic        eng_toggle,
  input  logic        eng_idle,
  input  logic [15:0] eng_rdata,
  output logic        init_done,
  output logic        busy,
  output logic        err
);

`ifdef AD9826_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RCW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [RCW-1:0] RTRY_MAX = RCW'(RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_LOAD, S_HOST_LOAD, S_VFY_LOAD, S_ASSERT, S_SHIFT, S_CAPTURE
  } state_t;

  state_t         state, state_nxt;
  logic [2:0]     idx;
  logic           is_host;   // current transaction belongs to the host
  logic           is_vfy;    // current init transaction is the readback
  logic [RCW-1:0] try_cnt;
  logic [TCW-1:0] tmo_cnt;
  logic           idle_meta, idle_s;
  logic [8:0]     init_word;
  logic           rd_mismatch, in_wait, tmo_hit;

  logic start_init, start_host, ld_init, ld_host, ld_vfy;
  logic tmo_abort, cap_host, cap_adv, cap_retry, cap_fail;

  // Bits intentionally ignored: engine readback above bit 8, host bits 11:9.
  logic unused_bits;
  assign unused_bits = &{1'b0, eng_rdata[15:9], host_word[11:9]};

  assign init_word   = init_image[9*int'(idx) +: 9];
  assign rd_mismatch = (eng_rdata[8:0] != init_word);
  assign in_wait     = (state == S_ASSERT) || (state == S_SHIFT);
  assign tmo_hit     = in_wait && (tmo_cnt == TMO_LAST);
  assign busy        = (state != S_IDLE);
  assign eng_toggle  = (state == S_ASSERT);

  always_comb begin
    state_nxt  = state;
    start_init = 1'b0;
    start_host = 1'b0;
    ld_init    = 1'b0;
    ld_host    = 1'b0;
    ld_vfy     = 1'b0;
    tmo_abort  = 1'b0;
    cap_host   = 1'b0;
    cap_adv    = 1'b0;
    cap_retry  = 1'b0;
    cap_fail   = 1'b0;
    case (state)
      S_IDLE: begin
        if (init_start) begin
          start_init = 1'b1;
          state_nxt  = S_INIT_LOAD;
        end else if (host_req && !host_ack) begin
          // host_ack guard: the host still holds req in its ack cycle
          start_host = 1'b1;
          state_nxt  = S_HOST_LOAD;
        end
      end
      S_INIT_LOAD: begin
        // Wait for the engine to be idle: after a reset mid-frame the engine
        // finishes its frame on its own before we may start a new one.
        if (idle_s) begin
          ld_init   = 1'b1;
          state_nxt = S_ASSERT;
        end
      end
      S_HOST_LOAD: begin
        ld_host   = 1'b1;
        state_nxt = S_ASSERT;
      end
      S_VFY_LOAD: begin
        ld_vfy    = 1'b1;
        state_nxt = S_ASSERT;
      end
      S_ASSERT: begin
        if (!idle_s) state_nxt = S_SHIFT;
        else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (idle_s) state_nxt = S_CAPTURE;
        else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (is_host) begin
          cap_host  = 1'b1;
          state_nxt = S_IDLE;
        end else if (VERIFY && !is_vfy) begin
          state_nxt = S_VFY_LOAD;
        end else if (VERIFY && rd_mismatch && (try_cnt != RTRY_MAX)) begin
          cap_retry = 1'b1;
          state_nxt = S_INIT_LOAD;
        end else begin
          cap_adv   = 1'b1;
          cap_fail  = VERIFY && rd_mismatch;
          state_nxt = (idx == 3'd7) ? S_IDLE : S_INIT_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT_LOAD;
      idx        <= '0;
      is_host    <= 1'b0;
      is_vfy     <= 1'b0;
      try_cnt    <= '0;
      tmo_cnt    <= '0;
      idle_meta  <= 1'b0;
      idle_s     <= 1'b0;
      eng_word   <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      init_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      idle_meta <= eng_idle;
      idle_s    <= idle_meta;
      state     <= state_nxt;
      host_ack  <= 1'b0;

      // Counter restarts on every state change, so it clears on entry to
      // ASSERT and again on entry to SHIFT.
      if (state_nxt != state) tmo_cnt <= '0;
      else if (in_wait)       tmo_cnt <= tmo_cnt + 1'b1;

      if (start_init) begin
        idx       <= '0;
        is_host   <= 1'b0;
        try_cnt   <= '0;
        init_done <= 1'b0;
        err       <= 1'b0;
      end
      if (start_host) is_host <= 1'b1;

      if (ld_init) begin
        eng_word <= {1'b0, idx, 3'b000, init_word};
        is_vfy   <= 1'b0;
      end
      if (ld_host) eng_word <= {host_word[15:12], 3'b000, host_word[8:0]};
      if (ld_vfy) begin
        eng_word <= {1'b1, idx, 12'h000};
        is_vfy   <= 1'b1;
      end

      if (cap_host) begin
        host_ack   <= 1'b1;
        host_rdata <= eng_rdata[8:0];
      end
      if (tmo_abort && is_host) begin
        host_ack   <= 1'b1;
        host_rdata <= '0;
      end
      if (cap_retry) try_cnt <= try_cnt + 1'b1;
      if (cap_adv) begin
        try_cnt <= '0;
        idx     <= idx + 1'b1;
        if (idx == 3'd7) init_done <= 1'b1;
      end
      if (cap_fail || tmo_abort) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ad9826_cfg_sequencer.sv
// Testbench for ad9826_cfg_sequencer: an AD9826 serial-engine model on the
// other side of the port, a reference model of the register image, and a
// scoreboard of expected engine words and host readbacks.
module tb_ad9826_cfg_sequencer;
  localparam int RETRIES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_start;
  logic [71:0] init_image;
  logic        host_req;
  logic [15:0] host_word;
  logic        host_ack;
  logic [8:0]  host_rdata;
  logic [15:0] eng_word;
  logic        eng_toggle;
  logic        eng_idle = 1'b1;
  logic [15:0] eng_rdata = 16'h0;
  logic        init_done, busy, err;

  always #5 clk = ~clk;

  ad9826_cfg_sequencer #(.TIMEOUT_CYCLES(4096), .RETRIES(RETRIES)) dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_image(init_image),
    .host_req(host_req), .host_word(host_word), .host_ack(host_ack),
    .host_rdata(host_rdata), .eng_word(eng_word), .eng_toggle(eng_toggle),
    .eng_idle(eng_idle), .eng_rdata(eng_rdata), .init_done(init_done),
    .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard queues and reference register image
  logic [15:0] exp_words[$];
  logic [8:0]  exp_rd[$];
  logic [8:0]  ref_regs[8];

  // Engine model: 6.25 MHz engine clock = one tick per 16 clk; sload low
  // for 16 engine clocks per accepted toggle.
  logic [8:0]  e_regs[8];
  bit          e_busy = 1'b0;
  int          e_div = 0;
  int          e_cnt = 0;
  logic [15:0] e_word = 16'h0;
  bit          stuck = 1'b0;
  int          corrupt_cnt = 0;
  bit          chk_after_rst = 1'b0;
  logic [2:0]  e_a;
  logic [8:0]  e_rv;

  always @(negedge clk) begin
    if (chk_after_rst && eng_toggle) begin
      chk("engine_idle_at_first_toggle_after_reset", 32'(e_busy), 0);
      chk_after_rst = 1'b0;
    end
    e_div = (e_div + 1) % 16;
    if (e_div == 0) begin
      if (!e_busy) begin
        if (eng_toggle && !stuck) begin
          e_busy   = 1'b1;
          e_cnt    = 0;
          e_word   = eng_word;
          eng_idle = 1'b0;
          if (exp_words.size() == 0) begin
            checks++; errors++;
            $display("FAIL eng_word: unexpected word %04h", eng_word);
          end else chk("eng_word", 32'(eng_word), 32'(exp_words.pop_front()));
        end
      end else begin
        e_cnt++;
        if (e_cnt == 16) begin
          e_a = e_word[14:12];
          if (!e_word[15]) e_regs[e_a] = e_word[8:0];
          e_rv = e_regs[e_a];
          if (e_word[15] && e_a == 3'd2 && corrupt_cnt > 0) begin
            e_rv = ~e_rv;
            corrupt_cnt--;
          end
          eng_rdata = {7'b0, e_rv};
          e_busy    = 1'b0;
          eng_idle  = 1'b1;
        end
      end
    end
  end

  // Host readback monitor
  always @(negedge clk) begin
    if (host_ack) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL host_ack: unexpected ack rdata %03h", host_rdata);
      end else chk("host_rdata", 32'(host_rdata), 32'(exp_rd.pop_front()));
    end
  end

  function automatic logic [8:0] img(input int k);
    return init_image[9*k +: 9];
  endfunction

  // Expected engine traffic for one init run from the current image.
  function automatic void push_init();
    for (int k = 0; k < 8; k++) begin
      logic [15:0] w;
      w = {1'b0, 3'(k), 3'b000, img(k)};
      ref_regs[k] = img(k);
`ifdef AD9826_VERIFY_EN
      begin
        int reps;
        reps = (k == 2) ? (((corrupt_cnt > RETRIES) ? RETRIES : corrupt_cnt) + 1) : 1;
        for (int r = 0; r < reps; r++) begin
          exp_words.push_back(w);
          exp_words.push_back({1'b1, 3'(k), 12'h000});
        end
      end
`else
      exp_words.push_back(w);
`endif
    end
  endfunction

  task automatic new_image();
    init_image = {8'($urandom), 32'($urandom), 32'($urandom)};
  endtask

  task automatic pulse_init();
    @(negedge clk) init_start = 1'b1;
    @(negedge clk) init_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!init_done && n < 12000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(init_done), 1);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_eng_word"},   32'(eng_word), 0);
    chk({pfx, "_eng_toggle"}, 32'(eng_toggle), 0);
    chk({pfx, "_host_ack"},   32'(host_ack), 0);
    chk({pfx, "_host_rdata"}, 32'(host_rdata), 0);
    chk({pfx, "_init_done"},  32'(init_done), 0);
    chk({pfx, "_busy"},       32'(busy), 1);
    chk({pfx, "_err"},        32'(err), 0);
  endtask

  task automatic host_txn(input logic [15:0] w);
    int n;
    logic [2:0] a;
    a = w[14:12];
    if (stuck) exp_rd.push_back(9'h000);
    else begin
      exp_words.push_back({w[15:12], 3'b000, w[8:0]});
      if (!w[15]) ref_regs[a] = w[8:0];
      exp_rd.push_back(ref_regs[a]);
    end
    @(negedge clk);
    host_word = w;
    host_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!host_ack && n < 8000);
    if (!host_ack) begin
      checks++; errors++;
      $display("FAIL host_ack_wait: got no ack required ack within 8000 cycles");
    end else chk("init_done_at_ack", 32'(init_done), 1);
    host_req = 1'b0;
    @(negedge clk);
    chk("host_ack_single_cycle", 32'(host_ack), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    init_start = 1'b0;
    host_req   = 1'b0;
    host_word  = 16'h0;
    for (int k = 0; k < 8; k++) e_regs[k] = 9'h0;
    new_image();
    repeat (3) @(negedge clk);
    chk_reset("reset");

    // Automatic init after reset release
    push_init();
    rst_n = 1'b1;
    wait_done("init_done_after_reset");
    chk("err_after_init", 32'(err), 0);
    chk("busy_after_init", 32'(busy), 0);

    // Host write then read of address 2, with bits 11:9 set in the request
    host_txn(16'h2E55);
    host_txn(16'hAE00);

    // Random host traffic
    for (int i = 0; i < 10; i++)
      host_txn({1'($urandom), 3'($urandom), 3'($urandom), 9'($urandom)});

    // Host request issued while an init run is in progress
    new_image();
    push_init();
    pulse_init();
    chk("busy_during_init", 32'(busy), 1);
    chk("init_done_cleared", 32'(init_done), 0);
    host_txn({1'b1, 3'($urandom), 12'h000});
    chk("err_after_held_host", 32'(err), 0);

    // Reset in the middle of the address-3 frame
    new_image();
    push_init();
    pulse_init();
    n = 0;
    while (!(e_busy && e_word[14:12] == 3'd3 && !e_word[15]) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_word3", 32'(e_busy && e_word[14:12] == 3'd3), 1);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    exp_words.delete();
    repeat (2) @(negedge clk);
    chk_reset("midreset");
    push_init();
    chk_after_rst = 1'b1;
    rst_n = 1'b1;
    wait_done("init_done_after_midreset");
    chk("err_after_midreset", 32'(err), 0);

    // Engine that never drops sload: host transaction times out
    stuck = 1'b1;
    host_txn(16'hB000);
    chk("err_after_host_timeout", 32'(err), 1);

    // Init run times out and aborts
    pulse_init();
    chk("err_cleared_by_init_start", 32'(err), 0);
    n = 0;
    while (!err && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("init_timeout_err", 32'(err), 1);
    chk("init_timeout_window", 32'(n >= 4090 && n <= 4105), 1);
    chk("toggle_low_after_timeout", 32'(eng_toggle), 0);
    chk("init_done_after_abort", 32'(init_done), 0);
    chk("idle_after_abort", 32'(busy), 0);

    // Recovery
    stuck = 1'b0;
    new_image();
    push_init();
    pulse_init();
    chk("err_cleared_again", 32'(err), 0);
    wait_done("init_done_after_recovery");
    chk("err_after_recovery", 32'(err), 0);
    host_txn({1'b1, 3'($urandom), 12'h000});

`ifdef AD9826_VERIFY_EN
    // Single corrupted readback: one rewrite, no error
    corrupt_cnt = 1;
    new_image();
    push_init();
    pulse_init();
    wait_done("init_done_corrupt_once");
    chk("err_corrupt_once", 32'(err), 0);
    // Persistent corruption: three writes to address 2, then error
    corrupt_cnt = 100;
    new_image();
    push_init();
    pulse_init();
    wait_done("init_done_corrupt_persist");
    chk("err_corrupt_persist", 32'(err), 1);
    corrupt_cnt = 0;
`endif

    repeat (20) @(negedge clk);
    chk("exp_words_drained", 32'(exp_words.size()), 0);
    chk("exp_rd_drained", 32'(exp_rd.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
